mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: maximum WAIT cycles for a read before an error response (range 1..255).
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have port clk, input, 1: rising-edge clock for all state.
REQ-004 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-005 SHALL have port Req_Valid, input, 2: per-requester request valid; bit i is requester i.
REQ-006 SHALL have port Req_Ready, output, 2: per-requester accept.
REQ-007 SHALL have port Req_Wr, input, 2: per-requester 1 = write, 0 = read.
REQ-008 SHALL have ports Req_Addr0 and Req_Addr1, input, 4 each: word address.
REQ-009 SHALL have ports Req_Data0 and Req_Data1, input, 32 each: write data.
REQ-010 SHALL have port Rsp_Valid, output, 2: one-cycle response strobe to requester i.
REQ-011 SHALL have port Rsp_Data, output, 32: read data, shared, qualified by Rsp_Valid.
REQ-012 SHALL have port Rsp_Err, output, 1: read timeout flag, qualified by Rsp_Valid.
REQ-013 SHALL have port Mem_EN, output, 1: memory access strobe.
REQ-014 SHALL have port Mem_WR, output, 1: 1 = write, 0 = read.
REQ-015 SHALL have ports Mem_Addr, output, 4, and Mem_Data_In, output, 32: access address and write data.
REQ-016 SHALL have ports Mem_Data_Out, input, 32, and Mem_Valid_Out, input, 1: read data and its strobe.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; exactly one transaction is in flight at a time.
REQ-018 In IDLE, SHALL assert Req_Ready (combinationally) only for the granted requester, and only while it has Req_Valid=1; all other Req_Ready bits SHALL be 0, and Req_Ready SHALL be 0 in every other state.
REQ-019 Grant SHALL be round-robin: if both are valid, grant the requester not granted last; if one is valid, grant it.
REQ-020 On handshake (Req_Valid[g]&Req_Ready[g]), SHALL latch g, Req_Wr[g], Req_AddrG and Req_DataG, update the last-grant pointer, and go to ISSUE.
REQ-021 In ISSUE, SHALL drive Mem_EN=1 for exactly one cycle with the latched WR, Addr and Data; then go to RESP on a write or to WAIT on a read.
REQ-022 Mem_EN SHALL be 0 outside ISSUE. Mem_WR, Mem_Addr and Mem_Data_In SHALL hold their last latched values.
REQ-023 In WAIT, SHALL count cycles from 1; on Mem_Valid_Out=1, capture Mem_Data_Out, set err=0 and go to RESP.
REQ-024 In WAIT, if the count reaches TIMEOUT without Mem_Valid_Out, SHALL set data=0 and err=1, then go to RESP.
REQ-025 Mem_Valid_Out SHALL be ignored outside WAIT; a late valid after a timeout SHALL have no effect.
REQ-026 In RESP, SHALL pulse Rsp_Valid[g] for one cycle, drive the captured Rsp_Data and Rsp_Err (write: data 0, err 0), then return to IDLE.
REQ-027 Rsp_Data and Rsp_Err SHALL be 0 whenever Rsp_Valid is 0.
REQ-028 Write latency SHALL be: accept at cycle T, Mem_EN at T+1, Rsp_Valid at T+2. A read with Mem_Valid_Out at T+2 SHALL give Rsp_Valid at T+3.
REQ-029 A new request SHALL be accepted no earlier than the IDLE cycle following RESP. Requests held valid across RESP SHALL be arbitrated then.
REQ-030 Changes of Req_* inputs after the handshake SHALL not affect the in-flight transaction.

Reset
REQ-031 While rst=1 at a clock edge, the FSM SHALL go to IDLE and the counter SHALL clear.
REQ-032 While rst=1, the last-grant pointer SHALL be set to 1, so requester 0 wins the first tie.
REQ-033 While rst=1, all outputs SHALL be 0: Req_Ready, Rsp_Valid, Rsp_Data, Rsp_Err, Mem_EN, Mem_WR, Mem_Addr and Mem_Data_In.
REQ-034 Reset asserted mid-transaction (ISSUE/WAIT/RESP) SHALL abort it with no Rsp_Valid.
REQ-035 While rst=1, Req_Ready SHALL be 0.

Verification
REQ-036 Req0 write, addr 3, data 0xDEADBEEF, alone -> Mem_EN=1, Mem_WR=1, Mem_Addr=3 at T+1; Rsp_Valid=2'b01, Rsp_Err=0 at T+2.
REQ-037 Req1 read, addr 3; memory returns Mem_Valid_Out with Mem_Data_Out=0xDEADBEEF at T+2 -> Rsp_Valid=2'b10, Rsp_Data=0xDEADBEEF at T+3.
REQ-038 Both requesters valid continuously after reset -> grant order 0,1,0,1 and never two consecutive grants to one requester.
REQ-039 Read with Mem_Valid_Out never asserted, TIMEOUT=15 -> Rsp_Valid after 15 WAIT cycles with Rsp_Err=1, Rsp_Data=0; a later stray Mem_Valid_Out is ignored.
REQ-040 rst=1 during WAIT -> next cycle all outputs 0, no Rsp_Valid; after release, pending requests from both requesters -> requester 0 granted first.
REQ-041 Req_Addr0 changed while the transaction is in WAIT -> the response reflects the latched address; Req_Ready stays 0 until IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter serialising single-word accesses to a memory with read timeout.
module mem_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  Req_Valid,
  output logic [1:0]  Req_Ready,
  input  logic [1:0]  Req_Wr,
  input  logic [3:0]  Req_Addr0,
  input  logic [3:0]  Req_Addr1,
  input  logic [31:0] Req_Data0,
  input  logic [31:0] Req_Data1,
  output logic [1:0]  Rsp_Valid,
  output logic [31:0] Rsp_Data,
  output logic        Rsp_Err,
  output logic        Mem_EN,
  output logic        Mem_WR,
  output logic [3:0]  Mem_Addr,
  output logic [31:0] Mem_Data_In,
  input  logic [31:0] Mem_Data_Out,
  input  logic        Mem_Valid_Out
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;
  logic last, cur, gnt;
  logic [7:0] cnt;
  logic [1:0] rsp_valid;
  logic [31:0] rsp_data, mem_data;
  logic rsp_err, mem_en, mem_wr;
  logic [3:0] mem_addr;
  always_comb begin
    gnt = (&Req_Valid) ? ~last : Req_Valid[1];
    Req_Ready = (state == IDLE && !rst) ? Req_Valid & (gnt ? 2'b10 : 2'b01) : 2'b00;
  end
  // outputs read zero while reset is held, even before the registers clear
  always_comb begin
    Rsp_Valid = rst ? 2'b00 : rsp_valid;
    Rsp_Data = rst ? 32'd0 : rsp_data;
    Rsp_Err = rst ? 1'b0 : rsp_err;
    Mem_EN = rst ? 1'b0 : mem_en;
    Mem_WR = rst ? 1'b0 : mem_wr;
    Mem_Addr = rst ? 4'd0 : mem_addr;
    Mem_Data_In = rst ? 32'd0 : mem_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last <= 1'b1;
      cur <= 1'b0;
      cnt <= '0;
      rsp_valid <= '0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
      mem_en <= 1'b0;
      mem_wr <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      case (state)
        IDLE: if (|Req_Ready) begin
          cur <= gnt;
          last <= gnt;
          mem_wr <= Req_Wr[gnt];
          mem_addr <= gnt ? Req_Addr1 : Req_Addr0;
          mem_data <= gnt ? Req_Data1 : Req_Data0;
          mem_en <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: begin
          mem_en <= 1'b0;
          cnt <= 8'd1;
          rsp_valid <= mem_wr ? {cur, ~cur} : 2'b00;
          state <= mem_wr ? RESP : WAIT;
        end
        WAIT: if (Mem_Valid_Out || cnt == 8'(TIMEOUT)) begin
          rsp_data <= Mem_Valid_Out ? Mem_Data_Out : 32'd0;
          rsp_err <= ~Mem_Valid_Out;
          rsp_valid <= {cur, ~cur};
          state <= RESP;
        end else begin
          cnt <= cnt + 8'd1;
        end
        RESP: begin
          rsp_valid <= '0;
          rsp_data <= '0;
          rsp_err <= 1'b0;
          cnt <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized transaction-level check of mem_arbiter against a memory/arbitration model.
module tb_mem_arbiter;
  localparam int TO = 15;
  logic clk = 0, rst = 1;
  logic [1:0] Req_Valid = 0, Req_Ready, Req_Wr = 0, Rsp_Valid;
  logic [3:0] Req_Addr0 = 0, Req_Addr1 = 0, Mem_Addr;
  logic [31:0] Req_Data0 = 0, Req_Data1 = 0, Rsp_Data, Mem_Data_In, Mem_Data_Out = 0;
  logic Rsp_Err, Mem_EN, Mem_WR, Mem_Valid_Out = 0;
  int checks = 0, errors = 0;
  int mode = 0, force_lat = 0;
  logic [31:0] mem [16];
  logic p_v [2];
  logic p_wr [2];
  logic [3:0] p_a [2];
  logic [31:0] p_d [2];
  logic last = 1;
  always #5 clk = ~clk;
  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_Wr(Req_Wr),
    .Req_Addr0(Req_Addr0), .Req_Addr1(Req_Addr1), .Req_Data0(Req_Data0), .Req_Data1(Req_Data1),
    .Rsp_Valid(Rsp_Valid), .Rsp_Data(Rsp_Data), .Rsp_Err(Rsp_Err), .Mem_EN(Mem_EN), .Mem_WR(Mem_WR),
    .Mem_Addr(Mem_Addr), .Mem_Data_In(Mem_Data_In), .Mem_Data_Out(Mem_Data_Out), .Mem_Valid_Out(Mem_Valid_Out)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic new_req(input int i);
    p_v[i] = 1;
    p_wr[i] = 1'($urandom);
    p_a[i] = 4'($urandom);
    p_d[i] = $urandom;
  endtask
  task automatic drive_req();
    Req_Valid = {p_v[1], p_v[0]};
    Req_Wr = {p_wr[1], p_wr[0]};
    Req_Addr0 = p_a[0];
    Req_Addr1 = p_a[1];
    Req_Data0 = p_d[0];
    Req_Data1 = p_d[1];
  endtask
  // after a handshake the request fields are junk; only pending valids persist
  task automatic scramble();
    Req_Valid = {p_v[1], p_v[0]};
    Req_Wr = 2'($urandom);
    Req_Addr0 = 4'($urandom);
    Req_Addr1 = 4'($urandom);
    Req_Data0 = $urandom;
    Req_Data1 = $urandom;
    Mem_Valid_Out = 1'($urandom);
    Mem_Data_Out = $urandom;
  endtask
  task automatic reset_seq();
    rst = 1;
    for (int i = 0; i < 2; i++) if (!p_v[i]) new_req(i);
    drive_req();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("rst_out", {Req_Ready, Rsp_Valid, Rsp_Err, Rsp_Data, Mem_EN, Mem_WR, Mem_Addr}, 0);
      check("rst_wdata", Mem_Data_In, 0);
      step();
    end
    rst = 0;
    last = 1;
  endtask
  task automatic do_txn(input int abort_k);
    int g, lat;
    logic acc, wr, exp_err;
    logic [3:0] a;
    logic [31:0] d, exp_data;
    acc = 0;
    g = 0;
    for (int n = 0; !acc; n++) begin
      for (int i = 0; i < 2; i++)
        if (!p_v[i] && (n >= 3 || mode == 1 || (mode == 0 && $urandom_range(0, 1) == 1))) new_req(i);
      drive_req();
      Mem_Valid_Out = 1'($urandom);
      Mem_Data_Out = $urandom;
      @(negedge clk);
      check("idle_quiet", {Rsp_Valid, Rsp_Err, Rsp_Data, Mem_EN}, 0);
      if (p_v[0] || p_v[1]) begin
        g = (p_v[0] && p_v[1]) ? (last ? 0 : 1) : (p_v[1] ? 1 : 0);
        check("grant", Req_Ready, g ? 2'b10 : 2'b01);
        acc = 1;
      end else check("ready_none", Req_Ready, 0);
      step();
    end
    wr = p_wr[g];
    a = p_a[g];
    d = p_d[g];
    last = g[0];
    p_v[g] = 0;
    if (mode == 1 || (mode == 0 && $urandom_range(0, 1) == 1)) new_req(g);
    scramble();
    @(negedge clk);
    check("issue", {Mem_EN, Mem_WR, Mem_Addr, Mem_Data_In}, {1'b1, wr, a, d});
    check("issue_idle", {Req_Ready, Rsp_Valid}, 0);
    step();
    lat = 0;
    if (wr) mem[a] = d;
    else begin
      lat = abort_k > 0 ? TO + 5 : (force_lat > 0 ? force_lat : $urandom_range(1, TO + 2));
      for (int k = 1; k <= TO; k++) begin
        scramble();
        Mem_Valid_Out = (k == lat);
        Mem_Data_Out = (k == lat) ? mem[a] : $urandom;
        if (k == abort_k) begin
          reset_seq();
          return;
        end
        @(negedge clk);
        check("wait", {Req_Ready, Rsp_Valid, Rsp_Err, Rsp_Data, Mem_EN}, 0);
        step();
        if (k == lat) break;
      end
    end
    exp_err = !wr && lat > TO;
    exp_data = (!wr && lat <= TO) ? mem[a] : 32'd0;
    scramble();
    if (exp_err) Mem_Valid_Out = 1;
    @(negedge clk);
    check("rsp", {Rsp_Valid, Rsp_Err, Rsp_Data}, {(g ? 2'b10 : 2'b01), exp_err, exp_data});
    check("rsp_hold", {Mem_EN, Mem_WR, Mem_Addr, Req_Ready}, {1'b0, wr, a, 2'b00});
    step();
  endtask
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    for (int i = 0; i < 2; i++) begin
      p_v[i] = 0; p_wr[i] = 0; p_a[i] = 0; p_d[i] = 0;
    end
    reset_seq();
    p_v[0] = 0;
    p_v[1] = 0;
    mode = 2;
    p_v[0] = 1; p_wr[0] = 1; p_a[0] = 4'd3; p_d[0] = 32'hDEADBEEF;
    do_txn(0);
    p_v[1] = 1; p_wr[1] = 0; p_a[1] = 4'd3; p_d[1] = $urandom;
    force_lat = 1;
    do_txn(0);
    p_v[0] = 1; p_wr[0] = 0; p_a[0] = 4'd7;
    force_lat = TO + 3;
    do_txn(0);
    force_lat = 0;
    mode = 1;
    for (int t = 0; t < 10; t++) do_txn(0);
    mode = 2;
    p_v[0] = 1; p_wr[0] = 0; p_a[0] = 4'd5;
    do_txn(3);
    do_txn(0);
    mode = 0;
    for (int t = 0; t < 150; t++) do_txn($urandom_range(0, 9) == 0 ? $urandom_range(1, TO) : 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
